// File: rtl/clk_gen_trim_ctrl.sv
`timescale 1ns/1ps
// clk_gen_trim_ctrl
//   Closed-loop trim controller for the ring-oscillator clock generator.
//   It enables the oscillator and waits for it to settle. It then counts
//   prescaled oscillator ticks over a fixed window of reference cycles and
//   steps the trim code until the count lies within target +/- tol.
//   After LOCK_CNT consecutive in-band windows it raises locked_o, and it
//   keeps measuring while locked.
//
// Ports
//   clk_i            reference clock, all logic on posedge
//   async_reset_n_i  asynchronous active-low reset
//   en_i             level enable of the calibration loop
//   target_i         desired ticks per window (used at each ADJUST)
//   tol_i            allowed deviation from target (used at each ADJUST)
//   osc_tick_i       single-cycle pulse per prescaled oscillator period (synced)
//   osc_en_o         ring-oscillator enable
//   trim_o           oscillator trim code, higher = faster
//   meas_o           tick count of the last completed window
//   meas_valid_o     one-cycle pulse when meas_o updates
//   locked_o         frequency in band for >= LOCK_CNT windows
//   err_o            sticky: trim saturated while out of band
//
// state    | meaning
// ---------+-------------------------------------------------------------
// IDLE     | loop off, oscillator disabled
// SETTLE   | oscillator running, waiting SETTLE_CYC cycles after a change
// MEASURE  | counting ticks over WINDOW cycles
// ADJUST   | one cycle: compare count to band, step trim or count lock
// FAIL     | trim saturated out of band; held until en_i drops
module clk_gen_trim_ctrl #(
  parameter int TRIM_W     = 5,
  parameter int TRIM_RESET = 16,
  parameter int CNT_W      = 16,
  parameter int WINDOW     = 1024,
  parameter int SETTLE_CYC = 64,
  parameter int LOCK_CNT   = 3
) (
  input  logic              clk_i,
  input  logic              async_reset_n_i,
  input  logic              en_i,
  input  logic [CNT_W-1:0]  target_i,
  input  logic [CNT_W-1:0]  tol_i,
  input  logic              osc_tick_i,
  output logic              osc_en_o,
  output logic [TRIM_W-1:0] trim_o,
  output logic [CNT_W-1:0]  meas_o,
  output logic              meas_valid_o,
  output logic              locked_o,
  output logic              err_o
);

  localparam int WIN_W = $clog2(WINDOW);
  localparam int SET_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
  localparam int LCK_W = $clog2(LOCK_CNT + 1);

  localparam logic [WIN_W-1:0]  WIN_LAST  = WIN_W'(WINDOW - 1);
  localparam logic [SET_W-1:0]  SET_LAST  = SET_W'(SETTLE_CYC - 1);
  localparam logic [LCK_W-1:0]  LCK_MAX   = LCK_W'(LOCK_CNT);
  localparam logic [TRIM_W-1:0] TRIM_INIT = TRIM_W'(TRIM_RESET);
  localparam logic [TRIM_W-1:0] TRIM_MAX  = '1;
  localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_MEASURE,
    ST_ADJUST,
    ST_FAIL
  } state_t;

  state_t            state;
  logic [CNT_W-1:0]  tick_cnt;
  logic [WIN_W-1:0]  win_cnt;
  logic [SET_W-1:0]  settle_cnt;
  logic [LCK_W-1:0]  lock_cnt;

  logic [CNT_W:0]    lo_diff;
  logic [CNT_W:0]    hi_sum;
  logic [CNT_W-1:0]  band_lo;
  logic [CNT_W-1:0]  band_hi;
  logic              below;
  logic              above;
  logic [CNT_W-1:0]  tick_next;
  logic [LCK_W-1:0]  lock_next;

  // Band limits use one extra bit so that target-tol underflow and
  // target+tol overflow clamp instead of wrapping.
  always_comb begin
    lo_diff   = {1'b0, target_i} - {1'b0, tol_i};
    hi_sum    = {1'b0, target_i} + {1'b0, tol_i};
    band_lo   = lo_diff[CNT_W] ? '0 : lo_diff[CNT_W-1:0];
    band_hi   = hi_sum[CNT_W] ? CNT_MAX : hi_sum[CNT_W-1:0];
    below     = (meas_o < band_lo);
    above     = (meas_o > band_hi);
    tick_next = (osc_tick_i && (tick_cnt != CNT_MAX)) ? tick_cnt + CNT_W'(1) : tick_cnt;
    lock_next = (lock_cnt == LCK_MAX) ? lock_cnt : lock_cnt + LCK_W'(1);
  end

  always_ff @(posedge clk_i or negedge async_reset_n_i) begin
    if (!async_reset_n_i) begin
      state        <= ST_IDLE;
      osc_en_o     <= 1'b0;
      trim_o       <= TRIM_INIT;
      meas_o       <= '0;
      meas_valid_o <= 1'b0;
      locked_o     <= 1'b0;
      err_o        <= 1'b0;
      tick_cnt     <= '0;
      win_cnt      <= '0;
      settle_cnt   <= '0;
      lock_cnt     <= '0;
    end else begin
      meas_valid_o <= 1'b0;
      if ((state != ST_IDLE) && !en_i) begin
        // Abort: partial window is thrown away, trim and last measurement kept.
        state      <= ST_IDLE;
        osc_en_o   <= 1'b0;
        locked_o   <= 1'b0;
        err_o      <= 1'b0;
        tick_cnt   <= '0;
        win_cnt    <= '0;
        settle_cnt <= '0;
        lock_cnt   <= '0;
      end else begin
        case (state)
          ST_IDLE: begin
            if (en_i) begin
              state      <= ST_SETTLE;
              osc_en_o   <= 1'b1;
              settle_cnt <= SET_LAST;
            end
          end

          ST_SETTLE: begin
            if (settle_cnt == '0) begin
              state    <= ST_MEASURE;
              tick_cnt <= '0;
              win_cnt  <= WIN_LAST;
            end else begin
              settle_cnt <= settle_cnt - SET_W'(1);
            end
          end

          ST_MEASURE: begin
            // The last window cycle's tick goes straight into meas_o.
            if (win_cnt == '0) begin
              meas_o       <= tick_next;
              meas_valid_o <= 1'b1;
              state        <= ST_ADJUST;
            end else begin
              tick_cnt <= tick_next;
              win_cnt  <= win_cnt - WIN_W'(1);
            end
          end

          ST_ADJUST: begin
            if (below || above) begin
              lock_cnt <= '0;
              locked_o <= 1'b0;
              if ((below && (trim_o == TRIM_MAX)) || (above && (trim_o == '0))) begin
                err_o <= 1'b1;
                state <= ST_FAIL;
              end else begin
                trim_o     <= below ? trim_o + TRIM_W'(1) : trim_o - TRIM_W'(1);
                state      <= ST_SETTLE;
                settle_cnt <= SET_LAST;
              end
            end else begin
              lock_cnt <= lock_next;
              if (lock_next == LCK_MAX) locked_o <= 1'b1;
              // Trim unchanged, so no settling needed before the next window.
              state    <= ST_MEASURE;
              tick_cnt <= '0;
              win_cnt  <= WIN_LAST;
            end
          end

          ST_FAIL: begin
            state <= ST_FAIL;
          end

          default: begin
            state <= ST_IDLE;
          end
        endcase
      end
    end
  end

endmodule
